// File: rtl/display_cursor_controller.sv
// ---------------------------------------------------------------------------
// display_cursor_controller
//
// Purpose: moves a digit cursor across a NUM_DIGITS display from three
// push buttons (left / center / right). Left and right auto-repeat while
// held. Center toggles the decimal point of the selected digit. The
// optional blink of the selected digit is enabled by defining the macro
// CURSOR_BLINK_EN. When it is undefined, digitBlank is tied to 0.
//
// Ports:
//   clock        in   sole clock, rising edge
//   resetN       in   asynchronous active-low reset
//   buttons[2:0] in   raw async buttons: [0] left, [1] center, [2] right
//   clearPoints  in   synchronous clear of all decimal points
//   cursorIndex  out  selected digit index
//   cursor       out  one-hot of cursorIndex
//   pointEnable  out  per-digit decimal-point enable
//   digitBlank   out  per-digit blank request (1 = blank)
// ---------------------------------------------------------------------------
module display_cursor_controller #(
    parameter int NUM_DIGITS        = 4,
    parameter int DEBOUNCE_BITS     = 16,
    parameter int REPEAT_DELAY_BITS = 24,
    parameter int REPEAT_RATE_BITS  = 21,
    parameter int BLINK_BITS        = 23,
    localparam int IDX_W = (NUM_DIGITS <= 2) ? 1 : $clog2(NUM_DIGITS)
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic [2:0]            buttons,
    input  logic                  clearPoints,
    output logic [IDX_W-1:0]      cursorIndex,
    output logic [NUM_DIGITS-1:0] cursor,
    output logic [NUM_DIGITS-1:0] pointEnable,
    output logic [NUM_DIGITS-1:0] digitBlank
);

    localparam int NUM_BTN  = 3;
    localparam int NUM_REP  = 2;  // lane 0 = left, lane 1 = right
    localparam int REP_W    = (REPEAT_DELAY_BITS > REPEAT_RATE_BITS) ?
                              REPEAT_DELAY_BITS : REPEAT_RATE_BITS;
    localparam logic [REP_W-1:0] DELAY_END = REP_W'((64'd1 << REPEAT_DELAY_BITS) - 64'd1);
    localparam logic [REP_W-1:0] RATE_END  = REP_W'((64'd1 << REPEAT_RATE_BITS) - 64'd1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } rep_state_t;

    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_REP-1:0] rep_level;
    logic [NUM_REP-1:0] rep_press;
    logic [NUM_REP-1:0] rep_step;

    // ------------------------------------------------------------------
    // Per-button synchroniser + debouncer + rising-edge press pulse
    // ------------------------------------------------------------------
    for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
        logic [1:0]               sync_q, sync_d;
        logic                     stable_q, stable_d;
        logic                     press_q, press_d;
        logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;

        always_comb begin
            sync_d   = {sync_q[0], buttons[b]};
            stable_d = stable_q;
            cnt_d    = '0;
            // Accept the new level only after it disagreed with the
            // stable level on 2^DEBOUNCE_BITS consecutive samples.
            if (sync_q[1] != stable_q) begin
                if (&cnt_q) stable_d = sync_q[1];
                else        cnt_d    = cnt_q + 1'b1;
            end
            press_d = stable_d & ~stable_q;
        end

        always_ff @(posedge clock or negedge resetN) begin
            if (!resetN) begin
                sync_q   <= '0;
                stable_q <= 1'b0;
                press_q  <= 1'b0;
                cnt_q    <= '0;
            end else begin
                sync_q   <= sync_d;
                stable_q <= stable_d;
                press_q  <= press_d;
                cnt_q    <= cnt_d;
            end
        end

        assign btn_level[b] = stable_q;
        assign btn_press[b] = press_q;
    end

    assign rep_level = {btn_level[2], btn_level[0]};
    assign rep_press = {btn_press[2], btn_press[0]};

    // ------------------------------------------------------------------
    // Auto-repeat FSM for left and right
    // ------------------------------------------------------------------
    for (genvar r = 0; r < NUM_REP; r++) begin : g_rep
        rep_state_t       state_q, state_d;
        logic [REP_W-1:0] cnt_q, cnt_d;
        logic             step;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            step    = 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (rep_press[r]) begin
                        state_d = S_DELAY;
                        step    = 1'b1;
                    end
                end
                S_DELAY: begin
                    if (!rep_level[r]) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DELAY_END) begin
                        state_d = S_REPEAT;
                        cnt_d   = '0;
                        step    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (!rep_level[r]) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == RATE_END) begin
                        cnt_d = '0;
                        step  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge clock or negedge resetN) begin
            if (!resetN) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign rep_step[r] = step;
    end

    // ------------------------------------------------------------------
    // Cursor index and decimal points
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] pts_q, pts_d;
    logic                  any_step;

    assign any_step = |rep_step;

    always_comb begin
        idx_d = idx_q;
        pts_d = pts_q;
        // Toggle uses the index held this cycle, before any step lands.
        if (btn_press[1]) pts_d[idx_q] = ~pts_q[idx_q];
        if (clearPoints)  pts_d = '0;
        // Left has priority; a simultaneous right step is dropped.
        if (rep_step[0])      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        else if (rep_step[1]) idx_d = (idx_q == '0) ? LAST_IDX : idx_q - 1'b1;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            idx_q <= '0;
            pts_q <= '0;
        end else begin
            idx_q <= idx_d;
            pts_q <= pts_d;
        end
    end

    assign cursorIndex = idx_q;
    assign pointEnable = pts_q;

    always_comb begin
        cursor        = '0;
        cursor[idx_q] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Optional blink of the selected digit
    // ------------------------------------------------------------------
`ifdef CURSOR_BLINK_EN
    logic [BLINK_BITS-1:0] blink_q, blink_d;

    // Restart the phase on a step so the new digit shows lit at once.
    always_comb blink_d = any_step ? '0 : blink_q + 1'b1;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) blink_q <= '0;
        else         blink_q <= blink_d;
    end

    always_comb begin
        digitBlank        = '0;
        digitBlank[idx_q] = blink_q[BLINK_BITS-1];
    end
`else
    logic unused_step;
    assign unused_step = any_step;
    assign digitBlank  = '0;
`endif

endmodule

// File: tb/tb_display_cursor_controller.sv
// ---------------------------------------------------------------------------
// tb_display_cursor_controller
//
// Directed and randomized button sequences against a reference model that
// schedules cursor steps / point toggles arithmetically from press and
// release times, then tracks the expected index, points and blink phase.
// ---------------------------------------------------------------------------
module tb_display_cursor_controller;

    localparam int N    = 3;
    localparam int DB   = 2;
    localparam int RD   = 4;
    localparam int RR   = 2;
    localparam int BB   = 3;
    localparam int MAXC = 8192;

    // Timing derived from the parameters: 2 sync flops + 2^DB debounce
    // samples, then the press pulse cycle.
    localparam int LAT  = 3 + (1 << DB);  // raw rise -> first step lands
    localparam int REL  = 2 + (1 << DB);  // raw fall -> last edge a step can land
    localparam int DLY  = 1 << RD;
    localparam int RATE = 1 << RR;

    logic       clock       = 1'b0;
    logic       resetN      = 1'b1;
    logic [2:0] buttons     = 3'b000;
    logic       clearPoints = 1'b0;
    logic [1:0] cursorIndex;
    logic [2:0] cursor;
    logic [2:0] pointEnable;
    logic [2:0] digitBlank;

    display_cursor_controller #(
        .NUM_DIGITS       (N),
        .DEBOUNCE_BITS    (DB),
        .REPEAT_DELAY_BITS(RD),
        .REPEAT_RATE_BITS (RR),
        .BLINK_BITS       (BB)
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .buttons    (buttons),
        .clearPoints(clearPoints),
        .cursorIndex(cursorIndex),
        .cursor     (cursor),
        .pointEnable(pointEnable),
        .digitBlank (digitBlank)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    bit lstep [MAXC];
    bit rstep [MAXC];
    bit ctog  [MAXC];

    int         exp_idx = 0;
    int         exp_age = 0;
    logic [2:0] exp_pts = 3'b000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] blank;
        chk("cursorIndex", {30'd0, cursorIndex}, exp_idx);
        chk("cursor", {29'd0, cursor}, 32'd1 << exp_idx);
        chk("pointEnable", {29'd0, pointEnable}, {29'd0, exp_pts});
`ifdef CURSOR_BLINK_EN
        blank = (((exp_age % (1 << BB)) >> (BB - 1)) & 1) != 0 ? (32'd1 << exp_idx) : 32'd0;
`else
        blank = 32'd0;
`endif
        chk("digitBlank", {29'd0, digitBlank}, blank);
    endtask

    function automatic void model_reset();
        exp_idx = 0;
        exp_pts = 3'b000;
        exp_age = 0;
    endfunction

    // Advance one clock edge, update the model for that edge, check outputs.
    task automatic tick();
        @(posedge clock);
        cyc++;
        if (!resetN) begin
            model_reset();
        end else if (cyc < MAXC) begin
            if (clearPoints)    exp_pts = 3'b000;
            else if (ctog[cyc]) exp_pts[exp_idx] = ~exp_pts[exp_idx];
            if (lstep[cyc])      exp_idx = (exp_idx + 1) % N;
            else if (rstep[cyc]) exp_idx = (exp_idx + N - 1) % N;
            exp_age = (lstep[cyc] || rstep[cyc]) ? 0 : exp_age + 1;
        end
        #1;
        check_all();
    endtask

    // Raw button rises just after edge a and falls just after edge a+hold.
    function automatic void sched(input int btn, input int a, input int hold);
        int k;
        int last;
        k    = a + LAT;
        last = a + hold + REL;
        if (btn == 1) begin
            if (k < MAXC) ctog[k] = 1'b1;
            return;
        end
        while (k <= last && k < MAXC) begin
            if (btn == 0) lstep[k] = 1'b1;
            else          rstep[k] = 1'b1;
            k += (k == a + LAT) ? DLY : RATE;
        end
    endfunction

    task automatic press(input logic [2:0] mask, input int hold, input int gap, input bit rnd_clr);
        buttons = mask;
        if (hold >= 4)
            for (int b = 0; b < 3; b++) if (mask[b]) sched(b, cyc, hold);
        for (int i = 0; i < hold + gap; i++) begin
            if (i == hold) buttons = 3'b000;
            clearPoints = rnd_clr ? ($urandom_range(0, 15) == 0) : 1'b0;
            tick();
        end
        clearPoints = 1'b0;
    endtask

    task automatic steer(input int target);
        for (int i = 0; i < N && exp_idx != target; i++) press(3'b100, 5, 12, 1'b0);
    endtask

    initial begin
        int hold;
        int a;

        // reset state
        #1 resetN = 1'b0;
        #1 model_reset();
        check_all();
        repeat (3) tick();
        resetN = 1'b1;
        repeat (4) tick();

        // glitch on left: too short to be accepted
        press(3'b001, $urandom_range(1, 3), 12, 1'b0);
        chk("glitch_idx", {30'd0, cursorIndex}, 32'd0);

        // right from 0 wraps to last digit, then steps down
        press(3'b100, $urandom_range(4, 10), 12, 1'b0);
        chk("wrap_cursor", {29'd0, cursor}, 32'd4);
        chk("wrap_idx", {30'd0, cursorIndex}, 32'd2);
        press(3'b100, $urandom_range(4, 10), 12, 1'b0);
        chk("right2_idx", {30'd0, cursorIndex}, 32'd1);
        steer(0);

        // left held: delay then repeat, wrapping mod 3
        press(3'b001, $urandom_range(36, 44), 14, 1'b0);

        // center toggles the selected point
        steer(1);
        press(3'b010, $urandom_range(4, 8), 12, 1'b0);
        chk("center_pts", {29'd0, pointEnable}, 32'd2);

        // center pulse and clearPoints in the same cycle: clear wins
        buttons = 3'b010;
        sched(1, cyc, LAT - 1);
        repeat (LAT - 1) tick();
        buttons     = 3'b000;
        clearPoints = 1'b1;
        tick();
        clearPoints = 1'b0;
        repeat (12) tick();
        chk("clear_pts", {29'd0, pointEnable}, 32'd0);

        // left and right together: left wins
        steer(0);
        press(3'b101, 6, 12, 1'b0);
        chk("lr_idx", {30'd0, cursorIndex}, 32'd1);

        // reset during auto-repeat, then a still-held button re-debounces
        buttons = 3'b001;
        sched(0, cyc, 500);
        repeat (30) tick();
        resetN = 1'b0;
        for (int k = cyc + 1; k < MAXC; k++) begin
            lstep[k] = 1'b0;
            rstep[k] = 1'b0;
            ctog[k]  = 1'b0;
        end
        #1 model_reset();
        check_all();
        repeat (3) tick();
        resetN = 1'b1;
        a      = cyc;
        hold   = $urandom_range(20, 30);
        sched(0, a, hold);
        repeat (hold) tick();
        buttons = 3'b000;
        repeat (14) tick();

        // randomized presses with sporadic clearPoints
        for (int n = 0; n < 30; n++) begin
            logic [2:0] m;
            case ($urandom_range(0, 6))
                0, 1:    m = 3'b001;
                2, 3:    m = 3'b100;
                4, 5:    m = 3'b010;
                default: m = 3'b101;
            endcase
            if ($urandom_range(0, 5) == 0) hold = $urandom_range(1, 3);
            else                           hold = $urandom_range(4, 50);
            press(m, hold, $urandom_range(10, 16), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/display_cursor_controller.md
DISPLAY_CURSOR_CONTROLLER -- requirements
Module: display_cursor_controller

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the number of display digits (legal 2..8).
REQ-002 Parameter DEBOUNCE_BITS, default 16, SHALL set debounce counter width (input stable 2^DEBOUNCE_BITS cycles to be accepted).
REQ-003 Parameter REPEAT_DELAY_BITS, default 24, SHALL set hold time before auto-repeat (2^REPEAT_DELAY_BITS cycles).
REQ-004 Parameter REPEAT_RATE_BITS, default 21, SHALL set the auto-repeat period (2^REPEAT_RATE_BITS cycles).
REQ-005 Parameter BLINK_BITS, default 23, SHALL set blink counter width; the blink phase is its MSB.
REQ-006 clock  input  1  sole clock, all state on rising edge.
REQ-007 resetN  input  1  asynchronous active-low reset.
REQ-008 buttons  input  3  raw asynchronous buttons, bit0 left, bit1 center, bit2 right, active-high.
REQ-009 clearPoints  input  1  synchronous request to clear all decimal points.
REQ-010 cursorIndex  output  max(1,$clog2(NUM_DIGITS))  selected digit index.
REQ-011 cursor  output  NUM_DIGITS  one-hot of cursorIndex, for LEDs.
REQ-012 pointEnable  output  NUM_DIGITS  per-digit decimal-point enable, to the segment controller.
REQ-013 digitBlank  output  NUM_DIGITS  per-digit blanking request, 1 = blank.

Function
REQ-014 Each button SHALL pass a 2-flop synchroniser, then a debouncer: counter increments while synced != stable, clears when equal; stable takes synced value when counter reaches all-ones.
REQ-015 A one-cycle press pulse SHALL be produced the cycle after a debounced stable level goes 0->1; release produces no pulse.
REQ-016 Left and right SHALL each run a repeat FSM: IDLE -> DELAY on press pulse (one step issued); DELAY -> REPEAT when the delay counter reaches all-ones (one step); in REPEAT one step each time the rate counter reaches all-ones; any state -> IDLE the cycle after the debounced level is 0.
REQ-017 A left step SHALL set cursorIndex to (cursorIndex+1) mod NUM_DIGITS; a right step to (cursorIndex-1) mod NUM_DIGITS; wrap in both directions, including non-power-of-2 NUM_DIGITS.
REQ-018 Left and right steps in the same cycle: left SHALL win; right step discarded.
REQ-019 Center press pulse SHALL toggle pointEnable[cursorIndex] using the index before any same-cycle step; center has no auto-repeat.
REQ-020 clearPoints high SHALL clear all pointEnable bits next edge, overriding a same-cycle toggle.
REQ-021 cursor SHALL equal 1<<cursorIndex combinationally; never zero or multi-hot.
REQ-022 Any cursor step SHALL clear the blink counter so the newly selected digit is visible immediately.

Reset
REQ-023 resetN low SHALL asynchronously force: cursorIndex 0, cursor 1, pointEnable 0, digitBlank 0, all FSMs IDLE, all counters 0, synchronisers and debounced levels 0.
REQ-024 Reset mid-hold SHALL abort repeat; after release of reset a still-held button SHALL be re-debounced and generate one fresh press pulse.

Configuration
REQ-025 Macro CURSOR_BLINK_EN defined: blink counter free-runs; digitBlank[cursorIndex] = blink MSB, other bits 0.
REQ-026 Macro CURSOR_BLINK_EN undefined: no blink counter instantiated; digitBlank tied to 0; REQ-022 void.

Verification (bench params: NUM_DIGITS=3, DEBOUNCE_BITS=2, REPEAT_DELAY_BITS=4, REPEAT_RATE_BITS=2, BLINK_BITS=3)
REQ-027 Left glitch high 2 cycles then low -> no step, cursorIndex stays 0.
REQ-028 Right clean press from reset -> cursorIndex 2 (wrap), cursor 3'b100; second right press -> 1.
REQ-029 Left held ~40 cycles -> one step at press, one after 16-cycle delay, then one every 4 cycles; index sequence 1,2,0,1... wraps mod 3.
REQ-030 Center press at index 1 -> pointEnable 3'b010; center press with clearPoints same cycle -> pointEnable 3'b000.
REQ-031 Left and right pulses same cycle at index 0 -> cursorIndex 1; resetN low mid-repeat -> all outputs reset values at once.
REQ-032 With CURSOR_BLINK_EN: digitBlank[cursorIndex] toggles every 4 cycles, reads 0 on the cycle after each step; without: digitBlank constant 0.
